ltc2195_frame_align: RTL and testbench



---
 rtl/ltc2195_pkg.sv | 16 +
 rtl/ltc2195_frame_align_sat_counter.sv | 22 ++
 rtl/ltc2195_frame_align.sv | 134 +++++++++++++
 tb/tb_ltc2195_frame_align.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ltc2195_pkg.sv
// Shared types and constants for the LTC2195 frame alignment controller.
package ltc2195_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } align_state_t;

  localparam logic [7:0] FR_PATTERN_DEF = 8'hF0;
  localparam int SLIP_W = 4;
  localparam int CNT_W  = 8;

endpackage

// File: rtl/ltc2195_frame_align_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && count != MAX)
      count <= count + W'(1);
  end

endmodule

// File: rtl/ltc2195_frame_align.sv
// Bitslip training controller for the LTC2195 frame lane.
// Optional stats ports/counters are built when FRAME_ALIGN_STATS_EN is defined.
module ltc2195_frame_align
  import ltc2195_pkg::*;
#(
  parameter logic [7:0] FR_PATTERN = FR_PATTERN_DEF,
  parameter int         SETTLE_CYC = 4,
  parameter int         LOCK_CNT   = 16,
  parameter int         LOSS_CNT   = 4,
  parameter int         MAX_SLIPS  = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [7:0]        fr_word_in,
  input  logic              word_valid_in,
  input  logic              retrain_in,
  output logic              bitslip_out,
  output logic              aligned_out,
  output logic              fail_out,
  output logic [SLIP_W-1:0] slip_count_out,
`ifdef FRAME_ALIGN_STATS_EN
  output logic [15:0]       err_count_out,
  output logic [7:0]        relock_count_out,
`endif
  output logic [2:0]        state_dbg_out
);

  localparam logic [SLIP_W-1:0] SETTLE_MAX  = SLIP_W'(SETTLE_CYC);
  localparam logic [SLIP_W-1:0] SETTLE_LAST = SLIP_W'(SETTLE_CYC - 1);
  localparam logic [SLIP_W-1:0] SLIP_MAX    = SLIP_W'(MAX_SLIPS);
  localparam logic [CNT_W-1:0]  LOCK_MAX    = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]  LOCK_LAST   = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0]  LOSS_MAX    = CNT_W'(LOSS_CNT);
  localparam logic [CNT_W-1:0]  LOSS_LAST   = CNT_W'(LOSS_CNT - 1);

  align_state_t      state, state_nxt;
  logic [SLIP_W-1:0] settle_cnt, slip_cnt;
  logic [CNT_W-1:0]  good_cnt, loss_cnt;
  logic              strobe_good, strobe_bad, lock_done, lost;

  // word_valid_in is a one-cycle strobe per sample with no backpressure: fr_word_in
  // is only looked at when it is high, and every counter holds while it is low.
  assign strobe_good = word_valid_in && (fr_word_in == FR_PATTERN);
  assign strobe_bad  = word_valid_in && (fr_word_in != FR_PATTERN);
  assign lock_done   = (state == ST_CHECK)  && strobe_good && (good_cnt == LOCK_LAST);
  assign lost        = (state == ST_LOCKED) && strobe_bad  && (loss_cnt == LOSS_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      state <= ST_SETTLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bitslip_out = 1'b0;
    aligned_out = 1'b0;
    fail_out    = 1'b0;
    if (retrain_in) begin
      state_nxt = ST_SETTLE;
    end else begin
      case (state)
        ST_SETTLE: if (word_valid_in && settle_cnt == SETTLE_LAST) state_nxt = ST_CHECK;
        ST_CHECK: begin
          if (lock_done)
            state_nxt = ST_LOCKED;
          else if (strobe_bad)
            state_nxt = (slip_cnt >= SLIP_MAX) ? ST_FAIL : ST_SLIP;
        end
        ST_SLIP:   state_nxt = ST_SETTLE;
        ST_LOCKED: if (lost) state_nxt = ST_CHECK;
        ST_FAIL:   state_nxt = ST_FAIL;
        default:   state_nxt = ST_SETTLE;
      endcase
    end
    // Outputs decode the registered state so a reset during SLIP drops bitslip at once.
    case (state)
      ST_SLIP:   bitslip_out = 1'b1;
      ST_LOCKED: aligned_out = 1'b1;
      ST_FAIL:   fail_out    = 1'b1;
      default:   ;
    endcase
  end

  sat_counter #(.W(SLIP_W), .MAX(SETTLE_MAX)) u_settle_cnt (
    .clk(clk_in), .rst_n(rst_n_in),
    .clr(retrain_in || state != ST_SETTLE),
    .en(state == ST_SETTLE && word_valid_in),
    .count(settle_cnt)
  );

  sat_counter #(.W(CNT_W), .MAX(LOCK_MAX)) u_good_cnt (
    .clk(clk_in), .rst_n(rst_n_in),
    .clr(retrain_in || state != ST_CHECK),
    .en(state == ST_CHECK && strobe_good),
    .count(good_cnt)
  );

  sat_counter #(.W(CNT_W), .MAX(LOSS_MAX)) u_loss_cnt (
    .clk(clk_in), .rst_n(rst_n_in),
    .clr(retrain_in || state != ST_LOCKED || strobe_good),
    .en(state == ST_LOCKED && strobe_bad),
    .count(loss_cnt)
  );

  // Automatic re-training starts a fresh attempt, so the slip budget is restored.
  sat_counter #(.W(SLIP_W), .MAX(SLIP_MAX)) u_slip_cnt (
    .clk(clk_in), .rst_n(rst_n_in),
    .clr(retrain_in || lost),
    .en(state == ST_SLIP),
    .count(slip_cnt)
  );

`ifdef FRAME_ALIGN_STATS_EN
  sat_counter #(.W(16), .MAX(16'hFFFF)) u_err_cnt (
    .clk(clk_in), .rst_n(rst_n_in),
    .clr(retrain_in),
    .en(state == ST_LOCKED && strobe_bad),
    .count(err_count_out)
  );

  sat_counter #(.W(8), .MAX(8'hFF)) u_relock_cnt (
    .clk(clk_in), .rst_n(rst_n_in),
    .clr(retrain_in),
    .en(lost),
    .count(relock_count_out)
  );
`endif

  assign slip_count_out = slip_cnt;
  assign state_dbg_out  = state;

endmodule

// File: tb/tb_ltc2195_frame_align.sv
// Directed bench for ltc2195_frame_align with a rotating frame-word ADC model.
module tb_ltc2195_frame_align;
  import ltc2195_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [7:0] fr_word_in;
  logic       word_valid_in;
  logic       retrain_in;
  logic       bitslip_out, aligned_out, fail_out;
  logic [3:0] slip_count_out;
  logic [2:0] state_dbg_out;
`ifdef FRAME_ALIGN_STATS_EN
  logic [15:0] err_count_out;
  logic [7:0]  relock_count_out;
`endif

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int pulses   = 0;
  int last_pulse = -1;
  int off      = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  ltc2195_frame_align #(
    .FR_PATTERN(8'hF0), .SETTLE_CYC(4), .LOCK_CNT(16), .LOSS_CNT(4), .MAX_SLIPS(8)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .fr_word_in(fr_word_in),
    .word_valid_in(word_valid_in),
    .retrain_in(retrain_in),
    .bitslip_out(bitslip_out),
    .aligned_out(aligned_out),
    .fail_out(fail_out),
    .slip_count_out(slip_count_out),
`ifdef FRAME_ALIGN_STATS_EN
    .err_count_out(err_count_out),
    .relock_count_out(relock_count_out),
`endif
    .state_dbg_out(state_dbg_out)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: each pulse pops the slip count the DUT should show during it.
  // The ADC model rotates the frame word by one bit on every pulse.
  always @(negedge clk_in) begin
    if (bitslip_out) begin
      pulses++;
      if (exp_q.size() != 0) check("slip_cnt_at_pulse", 32'(slip_count_out), 32'(exp_q.pop_front()));
      if (last_pulse >= 0) check("slip_gap_ge5", 32'((cyc - last_pulse) >= 5), 32'd1);
      last_pulse = cyc;
      off = (off == 0) ? 7 : off - 1;
    end
  end

  // ---------------- drivers ----------------
  function automatic logic [7:0] rot_word(input int o);
    logic [15:0] d;
    d = {8'hF0, 8'hF0} >> o;
    return d[7:0];
  endfunction

  task automatic drive(input logic v, input logic [7:0] w);
    word_valid_in = v;
    fr_word_in    = w;
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset();
    rst_n_in      = 1'b0;
    word_valid_in = 1'b0;
    retrain_in    = 1'b0;
    fr_word_in    = 8'h00;
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
  endtask

  task automatic new_scenario();
    pulses     = 0;
    last_pulse = -1;
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n_in = 1'b0; word_valid_in = 1'b0; retrain_in = 1'b0; fr_word_in = 8'h00;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_state", 32'(state_dbg_out), 32'(ST_SETTLE));
    check("rst_bitslip", 32'(bitslip_out), 32'd0);
    check("rst_aligned", 32'(aligned_out), 32'd0);
    check("rst_fail", 32'(fail_out), 32'd0);
    check("rst_slip_cnt", 32'(slip_count_out), 32'd0);

    // Aligned from reset; retrain collides with the lock-completing strobe.
    new_scenario();
    apply_reset();
    repeat (19) drive(1'b1, 8'hF0);
    check("s1_pre_lock_state", 32'(state_dbg_out), 32'(ST_CHECK));
    check("s1_pre_lock_aligned", 32'(aligned_out), 32'd0);
    retrain_in = 1'b1;
    drive(1'b1, 8'hF0);
    retrain_in = 1'b0;
    check("s1_retrain_prio_state", 32'(state_dbg_out), 32'(ST_SETTLE));
    check("s1_retrain_prio_aligned", 32'(aligned_out), 32'd0);
    repeat (19) drive(1'b1, 8'hF0);
    check("s1_19th_aligned", 32'(aligned_out), 32'd0);
    drive(1'b1, 8'hF0);
    check("s1_20th_aligned", 32'(aligned_out), 32'd1);
    check("s1_slip_cnt", 32'(slip_count_out), 32'd0);
    check("s1_pulses", 32'(pulses), 32'd0);

    // Never matches: 8 slips then FAIL, then retrain.
    new_scenario();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    apply_reset();
    for (int i = 0; i < 400 && !fail_out; i++) drive(1'b1, 8'h00);
    check("s3_fail", 32'(fail_out), 32'd1);
    check("s3_pulses", 32'(pulses), 32'd8);
    check("s3_slip_cnt", 32'(slip_count_out), 32'd8);
    repeat (30) drive(1'b1, 8'h00);
    check("s3_no_more_pulses", 32'(pulses), 32'd8);
    check("s3_fail_held", 32'(fail_out), 32'd1);
    retrain_in = 1'b1;
    drive(1'b1, 8'h00);
    retrain_in = 1'b0;
    check("s3_retrain_fail", 32'(fail_out), 32'd0);
    check("s3_retrain_state", 32'(state_dbg_out), 32'(ST_SETTLE));
    check("s3_retrain_slip_cnt", 32'(slip_count_out), 32'd0);
    check("s3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Frame rotated by 3: three slips, then lock.
    new_scenario();
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    off = 3;
    apply_reset();
    for (int i = 0; i < 300 && !aligned_out; i++) drive(1'b1, rot_word(off));
    check("s2_aligned", 32'(aligned_out), 32'd1);
    check("s2_pulses", 32'(pulses), 32'd3);
    check("s2_slip_cnt", 32'(slip_count_out), 32'd3);
    check("s2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Loss-of-lock: 3 bad, good, 3 bad, good, 3 bad keeps lock; 4th bad loses it.
    for (int g = 0; g < 2; g++) begin
      repeat (3) drive(1'b1, 8'h00);
      drive(1'b1, 8'hF0);
    end
    repeat (3) drive(1'b1, 8'h00);
    check("s4_still_locked", 32'(aligned_out), 32'd1);
    drive(1'b1, 8'h00);
    check("s4_lost_aligned", 32'(aligned_out), 32'd0);
    check("s4_lost_state", 32'(state_dbg_out), 32'(ST_CHECK));
    check("s4_lost_slip_cnt", 32'(slip_count_out), 32'd0);
`ifdef FRAME_ALIGN_STATS_EN
    check("s4_err_count", 32'(err_count_out), 32'd10);
    check("s4_relock_count", 32'(relock_count_out), 32'd1);
`else
    check("s4_pulses_kept", 32'(pulses), 32'd3);
`endif

    // valid low in CHECK with a bad word: frozen.
    repeat (50) drive(1'b0, 8'h00);
    check("s5_state_frozen", 32'(state_dbg_out), 32'(ST_CHECK));
    check("s5_no_pulse", 32'(pulses), 32'd3);

    // Reset during the SLIP cycle.
    drive(1'b1, 8'h00);
    check("s6_in_slip", 32'(bitslip_out), 32'd1);
    rst_n_in = 1'b0;
    #1;
    check("s6_async_bitslip", 32'(bitslip_out), 32'd0);
    check("s6_async_state", 32'(state_dbg_out), 32'(ST_SETTLE));
    check("s6_async_slip_cnt", 32'(slip_count_out), 32'd0);
    check("s6_async_aligned", 32'(aligned_out), 32'd0);
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    check("s6_pulse_suppressed", 32'(pulses), 32'd3);
    repeat (4) drive(1'b1, 8'hF0);
    check("s6_resume_check", 32'(state_dbg_out), 32'(ST_CHECK));
    repeat (16) drive(1'b1, 8'hF0);
    check("s6_relock", 32'(aligned_out), 32'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
